// File: rtl/monitor_prepare_ctrl.sv
// monitor_prepare_ctrl: controller behind the slot's prepare command (0x22).
// Holds the command's register bank and runs the busy/done status handshake
// that the monitor polls on 0x27. When an operation finishes, it can commit
// a page address to the serial/ID datapath and pulse a load strobe.
//
// Register map:
//   0x25 key   0x26 op   0x80/0x81 page address lo/hi   0x27 control/status
//   Any other address reads as 0xFF; writes to it are ignored.
//
// Ports:
//   clk_20mhz  system clock (rising edge)
//   reset      synchronous, active-high reset
//   wr_stb     one-cycle write strobe (addr <= wdata)
//   rd_stb     one-cycle read strobe
//   addr       register address within command 0x22
//   wdata      write data
//   rdata      read data, valid the cycle after rd_stb
//   rdata_vld  one-cycle pulse the cycle after rd_stb
//   busy       high while an operation is running
//   page_addr  committed page address {0x81, 0x80}
//   page_load  one-cycle pulse when page_addr updates
//   op_code    op value captured at start
//   error_o    (only with PREPARE_KEY_ERR_EN) mirrors ctrl[7]
//
// Optional feature macro: PREPARE_KEY_ERR_EN. When it is defined, a start
// request with the wrong key sets ctrl to 0x80 and raises error_o.
module monitor_prepare_ctrl #(
  parameter int unsigned BUSY_CYCLES = 200,
  parameter int unsigned WARM_READS  = 5,
  parameter logic [7:0]  KEY_VALUE   = 8'hA0
) (
  input  logic        clk_20mhz,
  input  logic        reset,
  input  logic        wr_stb,
  input  logic        rd_stb,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_vld,
  output logic        busy,
  output logic [15:0] page_addr,
  output logic        page_load,
`ifdef PREPARE_KEY_ERR_EN
  output logic [7:0]  op_code,
  output logic        error_o
`else
  output logic [7:0]  op_code
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  reg80_q, reg80_d;
  logic [7:0]  reg81_q, reg81_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  op_code_q, op_code_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  warm_q, warm_d;
  logic        first_done_q, first_done_d;
  logic [15:0] page_addr_q, page_addr_d;
  logic        page_load_q, page_load_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_vld_q, rdata_vld_d;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    op_d         = op_q;
    reg80_d      = reg80_q;
    reg81_d      = reg81_q;
    ctrl_d       = ctrl_q;
    op_code_d    = op_code_q;
    cnt_d        = cnt_q;
    warm_d       = warm_q;
    first_done_d = first_done_q;
    page_addr_d  = page_addr_q;
    page_load_d  = 1'b0;
    rdata_d      = rdata_q;
    rdata_vld_d  = rd_stb;

    // Countdown; the cycle that sees a count of 1 is the last busy cycle.
    if (state_q == StBusy) begin
      if (cnt_q == 16'd1) begin
        state_d      = StDone;
        ctrl_d       = 8'h00;
        first_done_d = 1'b1;
        if (op_code_q == 8'h06) begin
          page_addr_d = {reg81_q, reg80_q};
          page_load_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end

    if (wr_stb) begin
      case (addr)
        8'h25: key_d   = wdata;
        8'h26: op_d    = wdata;
        8'h80: reg80_d = wdata;
        8'h81: reg81_d = wdata;
        8'h27: begin
          // Control writes are locked out while busy, so a start can never
          // collide with the completion above.
          if (state_q != StBusy) begin
            if (wdata[0] && (key_q == KEY_VALUE)) begin
              ctrl_d    = wdata;
              op_code_d = op_q;
              cnt_d     = 16'(BUSY_CYCLES);
              state_d   = StBusy;
            end else begin
`ifdef PREPARE_KEY_ERR_EN
              ctrl_d = wdata[0] ? 8'h80 : wdata;
`else
              ctrl_d = wdata;
`endif
            end
          end
        end
        default: ;
      endcase
    end

    // Reads see this cycle's write (next-state values).
    if (rd_stb) begin
      case (addr)
        8'h25: rdata_d = key_d;
        8'h26: rdata_d = op_d;
        8'h80: rdata_d = reg80_d;
        8'h81: rdata_d = reg81_d;
        8'h27: begin
          // Warm-up flag: only during the first operation after reset, and
          // only for a limited number of status polls.
          if ((state_d == StBusy) && !first_done_d && (warm_q != 8'd0)) begin
            rdata_d = ctrl_d | 8'h20;
            warm_d  = warm_q - 8'd1;
          end else begin
            rdata_d = ctrl_d;
          end
        end
        default: rdata_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk_20mhz) begin
    if (reset) begin
      state_q      <= StIdle;
      key_q        <= 8'h00;
      op_q         <= 8'h00;
      reg80_q      <= 8'h00;
      reg81_q      <= 8'h00;
      ctrl_q       <= 8'h00;
      op_code_q    <= 8'h00;
      cnt_q        <= 16'd0;
      warm_q       <= 8'(WARM_READS);
      first_done_q <= 1'b0;
      page_addr_q  <= 16'h0000;
      page_load_q  <= 1'b0;
      rdata_q      <= 8'h00;
      rdata_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      op_q         <= op_d;
      reg80_q      <= reg80_d;
      reg81_q      <= reg81_d;
      ctrl_q       <= ctrl_d;
      op_code_q    <= op_code_d;
      cnt_q        <= cnt_d;
      warm_q       <= warm_d;
      first_done_q <= first_done_d;
      page_addr_q  <= page_addr_d;
      page_load_q  <= page_load_d;
      rdata_q      <= rdata_d;
      rdata_vld_q  <= rdata_vld_d;
    end
  end

  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;
  assign busy      = (state_q == StBusy);
  assign page_addr = page_addr_q;
  assign page_load = page_load_q;
  assign op_code   = op_code_q;
`ifdef PREPARE_KEY_ERR_EN
  assign error_o   = ctrl_q[7];
`endif

endmodule

// File: doc/monitor_prepare_ctrl.md
Name: monitor_prepare_ctrl

Overview:
- Controller behind the slot's prepare command (0x22) that sequences a monitor "prepare" transaction.
- Holds the 0x22 register bank: key 0x25, op 0x26, page address 0x80/0x81, control/status 0x27.
- Runs the busy/done status handshake the monitor polls on 0x27.
- On completion, configures the serial/ID datapath: latches a page address and pulses a load strobe.
- Sits between the slot byte decoder (decoded strobes in) and the serial register file (page select out).

Parameters:
- BUSY_CYCLES, 200, clk_20mhz cycles a started operation stays busy (counter width 16; minimum 1).
- WARM_READS, 5, status reads after the first start since reset that report the warm-up flag (bit 5).
- KEY_VALUE, 8'hA0, value 0x25 must hold for a start to be accepted.

Ports:
- clk_20mhz  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_stb  in  1  one-cycle pulse; write addr <= wdata.
- rd_stb  in  1  one-cycle pulse; read of addr.
- addr  in  8  register address within command 0x22.
- wdata  in  8  write data.
- rdata  out  8  read data; valid the cycle after rd_stb.
- rdata_vld  out  1  one-cycle pulse the cycle after rd_stb.
- busy  out  1  high while state is BUSY.
- page_addr  out  16  committed page address, {0x81, 0x80}.
- page_load  out  1  one-cycle pulse when page_addr updates.
- op_code  out  8  op value captured at start.

Behaviour:
- Reset values: all registers 0x00; rdata = 0x00, rdata_vld = 0, busy = 0, page_addr = 0x0000, page_load = 0, op_code = 0x00; state IDLE; warm_cnt = WARM_READS; first_done = 0.
- Writes to 0x25, 0x26, 0x80, 0x81 store wdata in any state.
- Writes to other addresses are ignored.
- A write to 0x27 in IDLE or DONE:
  - If wdata bit0 = 1 and key == KEY_VALUE: ctrl <= wdata, op_code <= op, counter <= BUSY_CYCLES, state -> BUSY.
  - Otherwise: ctrl <= wdata and the state is unchanged.
- A write to 0x27 while BUSY is ignored. No restart.
- States:
  - IDLE -> BUSY on an accepted start.
  - BUSY: counter decrements each cycle. When counter reaches 1, the next cycle moves to DONE.
  - DONE: stays until the next accepted start.
- BUSY -> DONE transition cycle:
  - ctrl <= 0x00 and first_done <= 1.
  - If op_code == 0x06: page_addr <= {reg81, reg80} and page_load = 1 for that cycle.
  - If op_code is 0x01 or 0x00: no page_load.
- Status read of 0x27:
  - BUSY with first_done = 0 and warm_cnt > 0: returns ctrl | 0x20, then warm_cnt decrements.
  - BUSY otherwise: returns ctrl.
  - IDLE or DONE: returns ctrl (0x00 after completion).
- Reads of 0x25, 0x26, 0x80, 0x81 return the stored value. Any other address returns 0xFF.
- Read latency is exactly 1 cycle. rd_stb and wr_stb in the same cycle: the write is applied first and the read returns the new value.
- A start write and the BUSY->DONE transition cannot coincide, because writes to 0x27 in BUSY are ignored.
- Reset mid-BUSY: everything returns to reset values and no page_load is issued.
- BUSY_CYCLES = 1: BUSY lasts exactly one cycle.

Optional Feature:
- Macro: PREPARE_KEY_ERR_EN.
- Defined: a 0x27 write with bit0 = 1 and key != KEY_VALUE sets ctrl <= 0x80 (error). The state does not change.
  - Reads of 0x27 return 0x80 until the next write to 0x27.
  - An error_o output (1 bit, reset 0) mirrors ctrl[7].
- Not defined: such writes just store wdata into ctrl, and there is no error_o port.

Test Plan:
- Warm-up, BUSY_CYCLES = 200: reset; W25=A0, W26=01, W80=00, W81=00, W27=09; 7 reads of 0x27 inside busy -> 29 x5 then 09 x2; after 200 cycles read -> 00; no page_load.
- Second sequence: W27=09 again, read of 0x27 while busy -> 09 (no bit5); after completion -> 00; busy high exactly 200 cycles.
- Page commit: W80=00, W81=02, W26=06, W27=03 -> status 03 while busy; on completion page_load is a single-cycle pulse with page_addr = 0x0200, op_code = 06; afterwards read of 0x27 -> 00.
- Bad key: W25=55, W27=09 -> busy stays 0; read of 0x27 -> 09 without the macro, 80 with it and error_o = 1.
- Busy lockout and reset: start, write W27=03 mid-busy -> ignored (status stays 09); assert reset mid-busy -> busy = 0, all readable registers 00, no page_load.
- Read misc: read 0x30 -> FF with rdata_vld one cycle after rd_stb; same-cycle W80=12 and R80 -> 12.
